// File: rtl/min_sad_tracker_mv.sv
// rtl/min_sad_tracker_mv.sv - running minimum-SAD tracker for motion-vector search
//
// Purpose: consumes one candidate SAD per valid cycle, tracks the smallest value
// and its 0-based arrival index, and presents the result once NUM_CAND samples
// have been seen. The result is held until the consumer acknowledges it.
//
// Ports:
//   in_clk        clock, rising edge
//   in_rst        asynchronous active-high reset
//   in_start      single-cycle request to begin (or restart) a search
//   in_sad        candidate SAD, SAD_WIDTH bits, unsigned
//   in_sad_valid  in_sad is valid this cycle
//   in_ack        consumer has taken the result
//   out_min_sad   final minimum SAD
//   out_min_idx   arrival index of the minimum
//   out_done      result valid, held until acknowledged
//   out_busy      high while searching
//   out_overrun   sticky: a sample arrived while not searching

module min_sad_tracker_mv #(
    parameter int SAD_WIDTH = 16,
    parameter int IDX_WIDTH = 9,
    parameter int NUM_CAND  = 289,
    parameter int TIE_LAST  = 0
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_start,
    input  logic [SAD_WIDTH-1:0] in_sad,
    input  logic                 in_sad_valid,
    input  logic                 in_ack,
    output logic [SAD_WIDTH-1:0] out_min_sad,
    output logic [IDX_WIDTH-1:0] out_min_idx,
    output logic                 out_done,
    output logic                 out_busy,
    output logic                 out_overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CAND - 1);
    localparam logic [SAD_WIDTH-1:0] SAD_ONES = {SAD_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic [SAD_WIDTH-1:0]   run_min_q, run_min_d;
    logic [IDX_WIDTH-1:0]   run_idx_q, run_idx_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SAD_WIDTH-1:0]   min_sad_q, min_sad_d;
    logic [IDX_WIDTH-1:0]   min_idx_q, min_idx_d;
    logic                   overrun_q, overrun_d;

    logic                   better;
    logic                   take;
    logic [SAD_WIDTH-1:0]   new_min;
    logic [IDX_WIDTH-1:0]   new_idx;

    // Candidate comparison; the first sample of a search is always taken so an
    // all-ones SAD still yields a valid index.
    always_comb begin
        better  = (TIE_LAST != 0) ? (in_sad <= run_min_q) : (in_sad < run_min_q);
        take    = (cnt_q == '0) || better;
        new_min = take ? in_sad : run_min_q;
        new_idx = take ? cnt_q  : run_idx_q;
    end

    always_comb begin
        state_d   = state_q;
        run_min_d = run_min_q;
        run_idx_d = run_idx_q;
        cnt_d     = cnt_q;
        min_sad_d = min_sad_q;
        min_idx_d = min_idx_q;
        overrun_d = overrun_q;

        if (in_start) begin
            // Start is honoured in every state: it begins a fresh search,
            // aborting one in progress or implicitly acknowledging a result.
            state_d   = S_SEARCH;
            run_min_d = SAD_ONES;
            run_idx_d = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_sad_valid) overrun_d = 1'b1;
                end
                S_SEARCH: begin
                    if (in_sad_valid) begin
                        run_min_d = new_min;
                        run_idx_d = new_idx;
                        if (cnt_q == LAST_IDX) begin
                            // Last candidate: publish including this sample and
                            // hold the counter rather than wrapping it.
                            state_d   = S_DONE;
                            min_sad_d = new_min;
                            min_idx_d = new_idx;
                        end else begin
                            cnt_d = cnt_q + IDX_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (in_sad_valid) overrun_d = 1'b1;
                    if (in_ack)       state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= S_IDLE;
            run_min_q <= SAD_ONES;
            run_idx_q <= '0;
            cnt_q     <= '0;
            min_sad_q <= '0;
            min_idx_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_min_q <= run_min_d;
            run_idx_q <= run_idx_d;
            cnt_q     <= cnt_d;
            min_sad_q <= min_sad_d;
            min_idx_q <= min_idx_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_min_sad = min_sad_q;
    assign out_min_idx = min_idx_q;
    assign out_done    = (state_q == S_DONE);
    assign out_busy    = (state_q == S_SEARCH);
    assign out_overrun = overrun_q;

endmodule

// File: tb/tb_min_sad_tracker_mv.sv
// tb/tb_min_sad_tracker_mv.sv - self-checking bench for min_sad_tracker_mv

module tb_min_sad_tracker_mv;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] sad;
    logic        valid;
    logic        ack;

    logic [15:0] sad_a, sad_b;
    logic [8:0]  idx_a, idx_b;
    logic        done_a, done_b, busy_a, busy_b, ovr_a, ovr_b;

    int vec_cnt = 0;
    int mis_cnt = 0;

    always #5 clk = ~clk;

    min_sad_tracker_mv #(.SAD_WIDTH(16), .IDX_WIDTH(9), .NUM_CAND(N), .TIE_LAST(0)) dut_a (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_sad(sad),
        .in_sad_valid(valid), .in_ack(ack), .out_min_sad(sad_a),
        .out_min_idx(idx_a), .out_done(done_a), .out_busy(busy_a),
        .out_overrun(ovr_a)
    );

    min_sad_tracker_mv #(.SAD_WIDTH(16), .IDX_WIDTH(9), .NUM_CAND(N), .TIE_LAST(1)) dut_b (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_sad(sad),
        .in_sad_valid(valid), .in_ack(ack), .out_min_sad(sad_b),
        .out_min_idx(idx_b), .out_done(done_b), .out_busy(busy_b),
        .out_overrun(ovr_b)
    );

    typedef struct {
        logic [3:0][15:0] s;
        logic [15:0]      exp_sad;
        logic [8:0]       exp_idx_first;
        logic [8:0]       exp_idx_last;
    } vec_t;

    // Reference model: samples of the current search kept in a queue and
    // the minimum found by a plain scan when the search completes.
    int          m_state;   // 0 idle, 1 search, 2 done
    int          m_q[$];
    logic [15:0] m_sad;
    logic [8:0]  m_i0, m_i1;
    logic        m_ovr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; valid = 1'b0; ack = 1'b0; sad = 16'h0;
    endtask

    task automatic model_reset();
        m_state = 0; m_q.delete(); m_sad = '0; m_i0 = '0; m_i1 = '0; m_ovr = 1'b0;
    endtask

    task automatic model_resolve();
        int best0, best1;
        best0 = 0; best1 = 0;
        for (int i = 1; i < m_q.size(); i++) begin
            if (m_q[i] <  m_q[best0]) best0 = i;
            if (m_q[i] <= m_q[best1]) best1 = i;
        end
        m_sad = 16'(m_q[best0]);
        m_i0  = 9'(best0);
        m_i1  = 9'(best1);
    endtask

    task automatic model_step(input logic st, input logic v, input logic [15:0] s, input logic ak);
        if (st) begin
            m_state = 1; m_q.delete(); m_ovr = 1'b0;
        end else if (m_state == 1) begin
            if (v) begin
                m_q.push_back(int'(s));
                if (m_q.size() == N) begin
                    model_resolve();
                    m_state = 2;
                end
            end
        end else begin
            if (v) m_ovr = 1'b1;
            if (ak && m_state == 2) m_state = 0;
        end
    endtask

    task automatic chk_result(input string nm, input logic [15:0] s, input logic [8:0] i0, input logic [8:0] i1);
        chk({nm, " done_a"}, done_a, 1'b1);
        chk({nm, " done_b"}, done_b, 1'b1);
        chk({nm, " busy"},   busy_a, 1'b0);
        chk({nm, " sad_a"},  sad_a, s);
        chk({nm, " sad_b"},  sad_b, s);
        chk({nm, " idx_a"},  idx_a, i0);
        chk({nm, " idx_b"},  idx_b, i1);
    endtask

    task automatic feed(input logic [15:0] s);
        valid = 1'b1; sad = s; step(); valid = 1'b0;
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{s: {16'd40, 16'd30, 16'd20, 16'd50},         exp_sad: 16'd20,     exp_idx_first: 9'd1, exp_idx_last: 9'd1};
        tbl[1] = '{s: {16'd9, 16'd5, 16'd5, 16'd10},            exp_sad: 16'd5,      exp_idx_first: 9'd1, exp_idx_last: 9'd2};
        tbl[2] = '{s: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp_sad: 16'hFFFF,   exp_idx_first: 9'd0, exp_idx_last: 9'd3};
        tbl[3] = '{s: {16'd0, 16'd0, 16'd0, 16'd0},             exp_sad: 16'd0,      exp_idx_first: 9'd0, exp_idx_last: 9'd3};
        tbl[4] = '{s: {16'd1, 16'd2, 16'd3, 16'd4},             exp_sad: 16'd1,      exp_idx_first: 9'd3, exp_idx_last: 9'd3};
        tbl[5] = '{s: {16'd4, 16'd3, 16'd2, 16'd1},             exp_sad: 16'd1,      exp_idx_first: 9'd0, exp_idx_last: 9'd0};
        tbl[6] = '{s: {16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF}, exp_sad: 16'hFFFE,   exp_idx_first: 9'd1, exp_idx_last: 9'd3};

        idle_inputs();
        rst = 1'b1;
        #12;
        chk("reset done",    done_a, 1'b0);
        chk("reset busy",    busy_a, 1'b0);
        chk("reset overrun", ovr_a,  1'b0);
        chk("reset sad",     sad_a,  16'h0);
        chk("reset idx",     idx_a,  9'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Table-driven searches, samples applied s[0] first.
        for (int t = 0; t < 7; t++) begin
            start = 1'b1; step(); start = 1'b0;
            chk($sformatf("tbl%0d busy", t), busy_a, 1'b1);
            for (int k = 0; k < N; k++) begin
                chk($sformatf("tbl%0d no early done", t), done_a, 1'b0);
                feed(tbl[t].s[k]);
            end
            chk_result($sformatf("tbl%0d", t), tbl[t].exp_sad, tbl[t].exp_idx_first, tbl[t].exp_idx_last);
            ack = 1'b1; step(); ack = 1'b0;
            chk($sformatf("tbl%0d ack done", t), done_a, 1'b0);
            chk($sformatf("tbl%0d ack busy", t), busy_a, 1'b0);
        end

        // Gapped valids with a held result.
        start = 1'b1; step(); start = 1'b0;
        feed(16'd7);
        for (int g = 0; g < 3; g++) step();
        feed(16'hFFFF); feed(16'd8); feed(16'd6);
        chk_result("gap", 16'd6, 9'd3, 9'd3);
        for (int h = 0; h < 5; h++) begin
            step();
            chk("gap hold done", done_a, 1'b1);
            chk("gap hold sad",  sad_a, 16'd6);
        end
        ack = 1'b1; step(); ack = 1'b0;
        chk("gap ack done", done_a, 1'b0);
        chk("gap ack busy", busy_a, 1'b0);

        // Abort: restart mid-search; the sample beside the restart is dropped.
        start = 1'b1; step(); start = 1'b0;
        feed(16'd1); feed(16'd2);
        start = 1'b1; valid = 1'b1; sad = 16'd0; step(); start = 1'b0; valid = 1'b0;
        chk("abort busy", busy_a, 1'b1);
        feed(16'd9); feed(16'd8); feed(16'd7); feed(16'd9);
        chk_result("abort", 16'd7, 9'd2, 9'd2);

        // Start in DONE acts as an ack; outputs keep their last values.
        start = 1'b1; step(); start = 1'b0;
        chk("implicit ack done", done_a, 1'b0);
        chk("implicit ack busy", busy_a, 1'b1);
        chk("implicit ack sad",  sad_a, 16'd7);
        feed(16'd3); feed(16'd3); feed(16'd3); feed(16'd3);
        ack = 1'b1; step(); ack = 1'b0;

        // Overrun in IDLE; ack outside DONE is ignored.
        valid = 1'b1; sad = 16'd0; ack = 1'b1; step(); valid = 1'b0; ack = 1'b0;
        chk("ovr set",      ovr_a,  1'b1);
        chk("ovr set b",    ovr_b,  1'b1);
        chk("ovr sad kept", sad_a,  16'd3);
        chk("ovr idx kept", idx_b,  9'd3);
        chk("ovr done",     done_a, 1'b0);
        step();
        chk("ovr sticky",   ovr_a,  1'b1);
        start = 1'b1; step(); start = 1'b0;
        chk("ovr clear",    ovr_a,  1'b0);

        // Reset mid-search after two valids, then a clean search.
        feed(16'd5); feed(16'd4);
        #2 rst = 1'b1;
        #1;
        chk("midrst sad",  sad_a,  16'h0);
        chk("midrst idx",  idx_b,  9'h0);
        chk("midrst busy", busy_a, 1'b0);
        chk("midrst done", done_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        feed(16'd4); feed(16'd3); feed(16'd2); feed(16'd1);
        chk_result("post rst", 16'd1, 9'd3, 9'd3);

        // Randomized run against the reference model.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic st, v, ak;
            logic [15:0] s;
            st = ($urandom_range(0, 24) == 0);
            v  = ($urandom_range(0, 3) != 0);
            ak = ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
            start = st; valid = v; ack = ak; sad = s;
            step();
            model_step(st, v, s, ak);
            chk("rnd done",    {done_b, done_a}, {2{m_state == 2}});
            chk("rnd busy",    {busy_b, busy_a}, {2{m_state == 1}});
            chk("rnd overrun", {ovr_b, ovr_a},   {2{m_ovr}});
            chk("rnd sad",     {sad_b, sad_a},   {m_sad, m_sad});
            chk("rnd idx",     {idx_b, idx_a},   {m_i1, m_i0});
        end

        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
